// File: rtl/ps2_key_ctrl_if.sv
// Key-event handshake bundle for ps2_key_ctrl: head-of-FIFO event plus valid/ready.
// The controller drives through the master modport; the consumer uses the slave modport.
interface ps2_key_ctrl_if;
  logic       evt_valid;
  logic       evt_rdy;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_ext,
    output evt_brk,
    input  evt_rdy
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_ext,
    input  evt_brk,
    output evt_rdy
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard receiver: input filtering, framing FSM, E0/F0 decode and event FIFO.
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses auto-repeated make events.
module ps2_key_ctrl #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           ps2c,
  input  logic           ps2d,
  ps2_key_ctrl_if.master evt,
  output logic           err_parity,
  output logic           err_frame,
  output logic           overflow,
  output logic           busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Filtered lines: index 0 is ps2c, index 1 is ps2d
  logic [1:0] raw;
  logic [1:0] filt;
  assign raw = {ps2d, ps2c};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_filt
      logic [FILT_LEN-1:0] sh_reg;
      logic                filt_reg;

      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          sh_reg   <= '1;
          filt_reg <= 1'b1;
        end else begin
          sh_reg <= {sh_reg[FILT_LEN-2:0], raw[gi]};
          if (&sh_reg)
            filt_reg <= 1'b1;
          else if (~|sh_reg)
            filt_reg <= 1'b0;
        end
      end

      assign filt[gi] = filt_reg;
    end
  endgenerate

  logic c_prev_reg;
  logic fall;
  logic d_bit;
  assign fall  = c_prev_reg & ~filt[0];
  assign d_bit = filt[1];

  state_t          state_reg, state_next;
  logic [2:0]      bit_cnt_reg, bit_cnt_next;
  logic [7:0]      data_reg, data_next;
  logic            par_reg, par_next;
  logic [TW-1:0]   to_cnt_reg, to_cnt_next;
  logic            byte_vld_reg, byte_vld_next;
  logic [7:0]      byte_reg, byte_next;
  logic            ext_pend_reg, ext_pend_next;
  logic            brk_pend_reg, brk_pend_next;
  logic            err_par_reg, err_par_next;
  logic            err_frm_reg, err_frm_next;
  logic            clr_pend;
  logic            dec_push;
  logic [9:0]      dec_ev;
  logic            push_req;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      c_prev_reg   <= 1'b1;
      state_reg    <= S_IDLE;
      bit_cnt_reg  <= '0;
      data_reg     <= '0;
      par_reg      <= 1'b0;
      to_cnt_reg   <= '0;
      byte_vld_reg <= 1'b0;
      byte_reg     <= '0;
      ext_pend_reg <= 1'b0;
      brk_pend_reg <= 1'b0;
      err_par_reg  <= 1'b0;
      err_frm_reg  <= 1'b0;
    end else begin
      c_prev_reg   <= filt[0];
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      data_reg     <= data_next;
      par_reg      <= par_next;
      to_cnt_reg   <= to_cnt_next;
      byte_vld_reg <= byte_vld_next;
      byte_reg     <= byte_next;
      ext_pend_reg <= ext_pend_next;
      brk_pend_reg <= brk_pend_next;
      err_par_reg  <= err_par_next;
      err_frm_reg  <= err_frm_next;
    end
  end

  // Framing: every transition is qualified by a filtered ps2c falling edge
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    data_next     = data_reg;
    par_next      = par_reg;
    byte_vld_next = 1'b0;
    byte_next     = byte_reg;
    err_par_next  = 1'b0;
    err_frm_next  = 1'b0;
    clr_pend      = 1'b0;
    to_cnt_next   = (fall || state_reg == S_IDLE) ? '0 : to_cnt_reg + TW'(1);

    if (fall) begin
      case (state_reg)
        S_IDLE: begin
          if (!d_bit) begin
            state_next   = S_DATA;
            bit_cnt_next = '0;
          end else begin
            err_frm_next = 1'b1;
          end
        end
        S_DATA: begin
          data_next    = {d_bit, data_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7)
            state_next = S_PARITY;
        end
        S_PARITY: begin
          par_next   = d_bit;
          state_next = S_STOP;
        end
        S_STOP: begin
          state_next = S_IDLE;
          if (!d_bit) begin
            err_frm_next = 1'b1;
            clr_pend     = 1'b1;
          end else if (!(^{data_reg, par_reg})) begin
            err_par_next = 1'b1;
            clr_pend     = 1'b1;
          end else begin
            byte_vld_next = 1'b1;
            byte_next     = data_reg;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end else if (state_reg != S_IDLE && to_cnt_reg == TO_LAST) begin
      state_next   = S_IDLE;
      err_frm_next = 1'b1;
      clr_pend     = 1'b1;
    end
  end

  // Prefix decode runs one cycle after a good stop bit
  always_comb begin
    ext_pend_next = ext_pend_reg;
    brk_pend_next = brk_pend_reg;
    dec_push      = 1'b0;
    dec_ev        = {ext_pend_reg, brk_pend_reg, byte_reg};
    if (byte_vld_reg) begin
      if (byte_reg == 8'hE0) begin
        ext_pend_next = 1'b1;
      end else if (byte_reg == 8'hF0) begin
        brk_pend_next = 1'b1;
      end else begin
        dec_push      = 1'b1;
        ext_pend_next = 1'b0;
        brk_pend_next = 1'b0;
      end
    end
    if (clr_pend) begin
      ext_pend_next = 1'b0;
      brk_pend_next = 1'b0;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       trk_vld_reg, trk_vld_next;
  logic [8:0] trk_reg, trk_next;
  logic       trk_hit;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      trk_vld_reg <= 1'b0;
      trk_reg     <= '0;
    end else begin
      trk_vld_reg <= trk_vld_next;
      trk_reg     <= trk_next;
    end
  end

  // Tracker is keyed on {ext, code}; the break flag only decides make vs release
  always_comb begin
    trk_vld_next = trk_vld_reg;
    trk_next     = trk_reg;
    trk_hit      = trk_vld_reg && (trk_reg == {dec_ev[9], dec_ev[7:0]});
    push_req     = 1'b0;
    if (dec_push) begin
      if (!dec_ev[8]) begin
        push_req     = !trk_hit;
        trk_next     = {dec_ev[9], dec_ev[7:0]};
        trk_vld_next = 1'b1;
      end else begin
        push_req = 1'b1;
        if (trk_hit)
          trk_vld_next = 1'b0;
      end
    end
  end
`else
  assign push_req = dec_push;
`endif

  logic [9:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          ovf_reg;
  logic          pop;
  logic          full;
  logic          push_ok;

  assign pop     = evt.evt_valid & evt.evt_rdy;
  assign full    = (count_reg == (PW+1)'(FIFO_DEPTH));
  assign push_ok = push_req & (~full | pop);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr_reg] <= dec_ev;
        wr_ptr_reg      <= wr_ptr_reg + PW'(1);
      end
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + (PW+1)'(push_ok) - (PW+1)'(pop);
      if (push_req && full && !pop)
        ovf_reg <= 1'b1;
    end
  end

  assign evt.evt_valid = (count_reg != '0);
  assign {evt.evt_ext, evt.evt_brk, evt.evt_code} = mem[rd_ptr_reg];

  assign err_parity = err_par_reg;
  assign err_frame  = err_frm_reg;
  assign overflow   = ovf_reg;
  assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Randomized bench for ps2_key_ctrl: frame-level reference model plus per-cycle event checker.
module tb_ps2_key_ctrl;
  localparam int FL = 8;
  localparam int TO = 1500;
  localparam int FD = 4;
  localparam int H  = 16;

  logic clk = 1'b0;
  logic clr;
  logic ps2c;
  logic ps2d;
  logic err_parity;
  logic err_frame;
  logic overflow;
  logic busy;

  ps2_key_ctrl_if bus ();

  ps2_key_ctrl #(
    .FILT_LEN   (FL),
    .TIMEOUT_CYC(TO),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .evt       (bus),
    .err_parity(err_parity),
    .err_frame (err_frame),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];
  int   exp_par = 0;
  int   exp_frm = 0;
  bit   exp_ovf = 1'b0;
  bit   m_ext = 1'b0;
  bit   m_brk = 1'b0;
  bit   trk_v = 1'b0;
  logic [8:0] trk = '0;

  int   seen_par = 0;
  int   seen_frm = 0;
  int   pop_cnt = 0;
  logic [9:0] last_pop = '0;
  int   rdy_mode = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decode of one complete frame, applied as the stop bit is driven
  task automatic model_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    logic [9:0] ev;
    bit push;
    if (stop_bad) begin
      exp_frm++;
      m_ext = 0;
      m_brk = 0;
    end else if (par_bad) begin
      exp_par++;
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      ev = {m_ext, m_brk, b};
      m_ext = 0;
      m_brk = 0;
      push = 1;
`ifdef PS2_TYPEMATIC_FILTER_EN
      if (!ev[8]) begin
        if (trk_v && trk == {ev[9], ev[7:0]}) push = 0;
        trk = {ev[9], ev[7:0]};
        trk_v = 1;
      end else if (trk_v && trk == {ev[9], ev[7:0]}) begin
        trk_v = 0;
      end
`endif
      if (push) begin
        if (exp_q.size() >= FD) exp_ovf = 1;
        else exp_q.push_back(ev);
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_ovf = 0;
    m_ext = 0;
    m_brk = 0;
    trk_v = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad, input int nbits);
    logic [10:0] fr;
    fr[0]   = 1'b0;
    fr[8:1] = b;
    fr[9]   = ~(^b) ^ par_bad;
    fr[10]  = ~stop_bad;
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1;
      ps2d = fr[i];
      repeat (H) @(posedge clk);
      #1;
      if (i == 10) model_frame(b, par_bad, stop_bad);
      ps2c = 1'b0;
      repeat (H) @(posedge clk);
      #1;
      ps2c = 1'b1;
    end
    repeat (H) @(posedge clk);
    #1;
    ps2d = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  task automatic send_glitch();
    @(posedge clk); #1;
    ps2d = 1'b1;
    repeat (H) @(posedge clk);
    #1;
    exp_frm++;
    ps2c = 1'b0;
    repeat (H) @(posedge clk);
    #1;
    ps2c = 1'b1;
    repeat (H) @(posedge clk);
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && !bus.evt_valid) done = 1;
    end
    chk("drain_timeout", {31'b0, done}, 32'd1);
    repeat (4) @(posedge clk);
  endtask

  task automatic checkpoint(input string tag);
    #1;
    chk({tag, "_par_cnt"}, seen_par, exp_par);
    chk({tag, "_frm_cnt"}, seen_frm, exp_frm);
    chk({tag, "_overflow"}, {31'b0, overflow}, {31'b0, exp_ovf});
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    $display("checkpoint %s: pops=%0d par=%0d frm=%0d ovf=%0b", tag, pop_cnt, seen_par, seen_frm, overflow);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'b0, bus.evt_valid}, 32'd0);
    chk({tag, "_code"}, {24'b0, bus.evt_code}, 32'd0);
    chk({tag, "_ext"}, {31'b0, bus.evt_ext}, 32'd0);
    chk({tag, "_brk"}, {31'b0, bus.evt_brk}, 32'd0);
    chk({tag, "_errp"}, {31'b0, err_parity}, 32'd0);
    chk({tag, "_errf"}, {31'b0, err_frame}, 32'd0);
    chk({tag, "_ovf"}, {31'b0, overflow}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    bus.evt_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.evt_rdy = 1'b0;
        1:       bus.evt_rdy = 1'b1;
        default: bus.evt_rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Event/err observer: every popped head must match the model's next event
  always @(negedge clk) begin
    if (!clr) begin
      if (err_parity) seen_par++;
      if (err_frame) seen_frm++;
      if (bus.evt_valid && bus.evt_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {22'b0, bus.evt_ext, bus.evt_brk, bus.evt_code}, 32'h3FF_FFFF);
        end else begin
          chk("event", {22'b0, bus.evt_ext, bus.evt_brk, bus.evt_code}, {22'b0, exp_q.pop_front()});
        end
        last_pop = {bus.evt_ext, bus.evt_brk, bus.evt_code};
        pop_cnt++;
        $display("pop %0d: ext=%0b brk=%0b code=%02h", pop_cnt, bus.evt_ext, bus.evt_brk, bus.evt_code);
      end else if (exp_q.size() == 0) begin
        chk("valid_when_empty", {31'b0, bus.evt_valid}, 32'd0);
      end
    end
  end

  initial begin
    int p0;
    int f0;
    logic [7:0] b;
    clr  = 1'b1;
    ps2c = 1'b1;
    ps2d = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    clr = 1'b0;
    repeat (20) @(posedge clk);

    // 1: plain make code
    p0 = pop_cnt;
    send_byte(8'h1C);
    wait_drain();
    chk("t1_pops", pop_cnt - p0, 32'd1);
    chk("t1_event", {22'b0, last_pop}, 32'h01C);
    chk("t1_par", seen_par, 32'd0);
    checkpoint("t1");

    // 2: extended break
    p0 = pop_cnt;
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    wait_drain();
    chk("t2_pops", pop_cnt - p0, 32'd1);
    chk("t2_event", {22'b0, last_pop}, 32'h375);
    checkpoint("t2");

    // 3: parity error clears a pending prefix
    p0 = pop_cnt;
    send_byte(8'hE0);
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    wait_drain();
    chk("t3_par", seen_par, 32'd1);
    chk("t3_nopop", pop_cnt - p0, 32'd0);
    send_byte(8'h1C);
    wait_drain();
    chk("t3_event", {22'b0, last_pop}, 32'h01C);
    checkpoint("t3");

    // 4: stray fall with data high, then timeout on a partial frame
    f0 = seen_frm;
    send_glitch();
    repeat (20) @(posedge clk);
    chk("t4_glitch", seen_frm, f0 + 1);
    send_frame(8'h5A, 1'b0, 1'b0, 5);
    repeat (200) @(posedge clk);
    #1;
    chk("t4_busy_mid", {31'b0, busy}, 32'd1);
    exp_frm++;
    repeat (TO + 100) @(posedge clk);
    chk("t4_timeout", seen_frm, f0 + 2);
    send_byte(8'h2B);
    wait_drain();
    chk("t4_event", {22'b0, last_pop}, 32'h02B);
    checkpoint("t4");

    // 5: overflow with the consumer stalled
    rdy_mode = 0;
    p0 = pop_cnt;
    for (int k = 0; k < 6; k++) send_byte(8'h15 + 8'(k));
    repeat (20) @(posedge clk);
    #1;
    chk("t5_overflow", {31'b0, overflow}, 32'd1);
    chk("t5_valid", {31'b0, bus.evt_valid}, 32'd1);
    chk("t5_head", {24'b0, bus.evt_code}, 32'h15);
    rdy_mode = 1;
    wait_drain();
    chk("t5_pops", pop_cnt - p0, 32'd4);
    chk("t5_last", {22'b0, last_pop}, 32'h018);
    checkpoint("t5");

    // 6: reset mid-frame with a queued event and sticky overflow
    rdy_mode = 0;
    send_byte(8'h22);
    send_frame(8'h33, 1'b0, 1'b0, 4);
    @(posedge clk); #2;
    clr = 1'b1;
    model_reset();
    #1;
    chk_reset_outputs("t6_clr");
    repeat (5) @(posedge clk);
    #1;
    clr = 1'b0;
    rdy_mode = 1;
    repeat (20) @(posedge clk);
    p0 = pop_cnt;
    send_byte(8'h1C);
    send_byte(8'h1C);
    wait_drain();
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("t6_repeat_pops", pop_cnt - p0, 32'd1);
`else
    chk("t6_repeat_pops", pop_cnt - p0, 32'd2);
`endif
    checkpoint("t6");

    // Randomized traffic
    rdy_mode = 2;
    for (int n = 0; n < 50; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, 11);
      if (n % 10 == 9) begin
        wait_drain();
        checkpoint("rand");
      end
    end
    wait_drain();
    chk("final_queue", exp_q.size(), 32'd0);
    checkpoint("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
Receive-side controller for the PS/2 keyboard port. It filters raw PS/2 clock and data, frames 11-bit packets with an explicit FSM, and checks start, parity and stop bits. It decodes E0 (extended) and F0 (break) prefixes into single key events and queues them in a small FIFO with a valid/ready handshake. It sits between the PS/2 pins and the keyboard consumer logic, and replaces free-running scan-code shifting with sequenced, error-checked key events.

Parameters:
FILT_LEN, 8, number of clk samples that must agree before filtered ps2c/ps2d change
TIMEOUT_CYC, 100000, clk cycles without a filtered ps2c falling edge before a partial frame is aborted
FIFO_DEPTH, 4, event FIFO entries; power of two, ≥2

Ports:
clk  in  1  system clock
clr  in  1  reset, asynchronous, active-high
ps2c  in  1  raw PS/2 clock (asynchronous)
ps2d  in  1  raw PS/2 data (asynchronous)
evt_rdy  in  1  consumer accepts head event
evt_valid  out  1  FIFO non-empty
evt_code  out  8  scan code of head event
evt_ext  out  1  head event had E0 prefix
evt_brk  out  1  head event had F0 prefix (key release)
err_parity  out  1  one-cycle pulse: parity error
err_frame  out  1  one-cycle pulse: bad start/stop or timeout
overflow  out  1  sticky: an event was dropped because the FIFO was full
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: clr asynchronously and active-high clears all state. Filtered clock and data go to 1. FSM goes to IDLE. FIFO empties. Pendings clear. Outputs: evt_valid 0, evt_code 0, evt_ext 0, evt_brk 0, err_* 0, overflow 0, busy 0.
- Reset mid-frame discards the partial frame. No event or error is emitted.
- Filter: FILT_LEN-bit shift per input. Filtered value becomes 1 on all-ones and 0 on all-zeros; otherwise it holds.
- Falling-edge detect: registered copy of filtered ps2c; fall = prev & ~cur. All logic is in the clk domain; no derived clocks.
- FSM states and transitions, each advancing only on a fall cycle:
  - IDLE: a fall with data 0 goes to DATA. A fall with data 1 pulses err_frame and stays in IDLE.
  - DATA: shifts data LSB-first; moves to PARITY after 8 bits (bit counter 0..7).
  - PARITY: samples the parity bit and goes to STOP.
  - STOP: samples the stop bit and goes to IDLE. The byte is valid when stop = 1 and XOR(data, parity) = 1 (odd parity).
- Error priority on STOP: a bad stop bit pulses err_frame only. Otherwise a bad parity pulses err_parity. An erroneous byte is discarded and clears ext_pending and brk_pending.
- Timeout: the counter clears on every fall and in IDLE, and increments otherwise. When it reaches TIMEOUT_CYC-1 outside IDLE: FSM goes to IDLE, err_frame pulses, pendings clear.
- Decode, in the cycle after a valid STOP:
  - E0 sets ext_pending.
  - F0 sets brk_pending.
  - Any other byte pushes {ext_pending, brk_pending, byte} and clears both pendings.
  - An E0 after F0 keeps brk_pending.
- Latency: the push happens 1 clk after the stop-bit fall cycle. evt_valid rises on the next clk edge when the FIFO was empty.
- FIFO:
  - Pop when evt_valid & evt_rdy.
  - A push when full with no simultaneous pop drops the event and sets overflow (cleared only by clr).
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Push and pop in the same cycle when empty: not possible, since the head is not yet valid.
  - Pointers wrap modulo FIFO_DEPTH.
  - Head fields hold their value while evt_valid & ~evt_rdy.
- busy = (state != IDLE).

Optional Feature:
Macro PS2_TYPEMATIC_FILTER_EN.
- Defined: the block tracks the last pushed make event {ext, code}. A make event identical to it, with no break of that key in between, is suppressed (auto-repeat removed). A break of that key clears the tracker. Reset clears the tracker.
- Not defined: every decoded event is pushed, including typematic repeats.

Test Plan:
1. Frame 0x1C (start 0, data LSB-first, parity 0, stop 1), evt_rdy=1 -> one event: code 1C, ext 0, brk 0; no err pulses.
2. Frames E0, F0, 75 -> exactly one event: code 75, ext 1, brk 1; no events for the prefixes.
3. Frame 0x1C with parity bit 1 -> err_parity pulses once; no event; a following good 0x1C yields a normal event with ext 0, brk 0.
4. Start bit plus 4 data bits, then ps2c held high for TIMEOUT_CYC cycles -> err_frame pulses once, busy falls to 0, FSM is in IDLE; the next full frame decodes correctly.
5. evt_rdy=0, six make frames 0x15..0x1A with FIFO_DEPTH=4 -> overflow=1; after raising evt_rdy, codes 15,16,17,18 pop in order, then evt_valid=0.
6. clr asserted mid-DATA -> all outputs return to reset values immediately; with PS2_TYPEMATIC_FILTER_EN defined, a repeated 0x1C make (no intervening break) yields one event only.
